// File: rtl/pdm_pkg.sv
// Shared types and constants for the PCM frame packer and its SPI-side helpers.
package pdm_pkg;

  // Write-side FSM states.
  typedef enum logic [0:0] {
    IDLE,
    EMIT
  } packer_state_t;

  // Sync byte that leads each frame when the header is enabled.
  localparam logic [7:0] FRAME_SYNC = 8'hA5;

  // Width of the saturating drop counter.
  localparam int unsigned DROP_CNT_W = 16;

  // Index width for a counter over n items, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/busy_edge_sync.sv
// Three-flop synchroniser for an asynchronous level plus a rising-edge detector.
// The edge is taken between the second and third flop so the detector never
// sees the possibly metastable first stage.
module busy_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic [2:0] sync_q;

  // Shift the asynchronous level through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], async_in};
    end
  end

  assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/pcm_frame_packer.sv
// Multi-channel PCM frame packer: latches one sample per channel, writes the set
// as an interleaved little-endian byte frame to an external FIFO, and serves
// FIFO bytes to the SPI slave on each transfer start.
// Build option: define PACKER_HEADER_EN to prefix every frame with a sync byte
// and an 8-bit sequence number.
module pcm_frame_packer
  import pdm_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 2,
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned FREE_WIDTH   = 20,
  parameter logic [7:0]  FILL_BYTE    = 8'h00
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 sample_valid,
  input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] sample_data,
  output logic                                 fifo_wr_en,
  output logic [7:0]                           fifo_wr_data,
  input  logic                                 fifo_full,
  input  logic [FREE_WIDTH-1:0]                fifo_free,
  output logic                                 fifo_rd_en,
  input  logic [7:0]                           fifo_rd_data,
  input  logic                                 fifo_empty,
  input  logic                                 spi_busy,
  output logic [7:0]                           tx_data,
  output logic                                 tx_valid,
  input  logic                                 stat_clr,
  output logic [15:0]                          drop_count,
  output logic                                 overrun
);

  localparam int unsigned BYTES_PER_SAMPLE = (SAMPLE_WIDTH + 7) / 8;
`ifdef PACKER_HEADER_EN
  localparam int unsigned HDR_BYTES = 2;
`else
  localparam int unsigned HDR_BYTES = 0;
`endif
  localparam int unsigned FRAME_BYTES = NUM_CHANNELS * BYTES_PER_SAMPLE + HDR_BYTES;
  localparam int unsigned IDX_W       = idx_width(FRAME_BYTES);
  localparam int unsigned DATA_W      = NUM_CHANNELS * SAMPLE_WIDTH;
  localparam int unsigned CMP_W       = (FREE_WIDTH > 32) ? FREE_WIDTH : 32;

  localparam logic [IDX_W-1:0] LAST_IDX        = IDX_W'(FRAME_BYTES - 1);
  localparam logic [CMP_W-1:0] FRAME_BYTES_CMP = CMP_W'(FRAME_BYTES);

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------

  packer_state_t          state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_W-1:0]      shadow_q, shadow_d;
  logic [DROP_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic                   overrun_q, overrun_d;

  logic                   space_ok;
  logic                   drop;
  logic                   wr_fire;
  logic [7:0]             frame_bytes [FRAME_BYTES];
  logic [7:0]             cur_byte;

  // Whole-frame admission: a frame is only started if every byte already fits.
  assign space_ok = CMP_W'(fifo_free) >= FRAME_BYTES_CMP;

`ifdef PACKER_HEADER_EN
  logic [7:0] seq_q;

  // Sequence advances when a frame's last byte is written, so drops never consume a number.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q <= 8'd0;
    end else if (wr_fire && (idx_q == LAST_IDX)) begin
      seq_q <= seq_q + 8'd1;
    end
  end
`endif

  // Lay the shadowed samples out as sign-extended little-endian bytes, channel 0 first.
  always_comb begin
    for (int b = 0; b < FRAME_BYTES; b++) begin
      frame_bytes[b] = 8'h00;
    end
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      for (int k = 0; k < BYTES_PER_SAMPLE * 8; k++) begin
        // Bits above the sample width replicate the sample's sign bit.
        frame_bytes[HDR_BYTES + c * BYTES_PER_SAMPLE + k / 8][k % 8] =
            shadow_q[c * SAMPLE_WIDTH + ((k < SAMPLE_WIDTH) ? k : SAMPLE_WIDTH - 1)];
      end
    end
`ifdef PACKER_HEADER_EN
    frame_bytes[0] = FRAME_SYNC;
    frame_bytes[1] = seq_q;
`endif
  end

  assign cur_byte = frame_bytes[idx_q];

  // Write FSM next state: admit or drop in IDLE, stream one byte per non-full cycle in EMIT.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    drop     = 1'b0;
    wr_fire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample_valid) begin
          if (space_ok) begin
            shadow_d = sample_data;
            idx_d    = '0;
            state_d  = EMIT;
          end else begin
            drop = 1'b1;
          end
        end
      end
      EMIT: begin
        // A new set arriving mid-frame is dropped; the frame in flight stays intact.
        drop = sample_valid;
        if (!fifo_full) begin
          wr_fire = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write FSM state, byte index and sample shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
    end
  end

  assign fifo_wr_en   = wr_fire;
  assign fifo_wr_data = wr_fire ? cur_byte : 8'h00;

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------

  // Clear takes priority over a coincident drop; the counter saturates at all-ones.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    overrun_d  = overrun_q;
    if (stat_clr) begin
      drop_cnt_d = '0;
      overrun_d  = 1'b0;
    end else if (drop) begin
      overrun_d = 1'b1;
      if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + 1'b1;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      overrun_q  <= overrun_d;
    end
  end

  assign drop_count = drop_cnt_q;
  assign overrun    = overrun_q;

  // ---------------------------------------------------------------------------
  // Read side
  // ---------------------------------------------------------------------------

  logic       busy_rise;
  logic       rd_en_q;
  logic       rd_wait_q;
  logic [7:0] tx_data_q;
  logic       tx_valid_q;

  busy_edge_sync u_busy_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (spi_busy),
    .rise     (busy_rise)
  );

  // Serve one byte per transfer start: fill byte when empty, else a one-cycle FIFO read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en_q    <= 1'b0;
      rd_wait_q  <= 1'b0;
      tx_data_q  <= FILL_BYTE;
      tx_valid_q <= 1'b0;
    end else begin
      rd_en_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      // Read data is valid the cycle after the strobe.
      rd_wait_q  <= rd_en_q;
      if (rd_wait_q) begin
        tx_data_q  <= fifo_rd_data;
        tx_valid_q <= 1'b1;
      end else if (busy_rise && !rd_en_q) begin
        if (fifo_empty) begin
          tx_data_q  <= FILL_BYTE;
          tx_valid_q <= 1'b1;
        end else begin
          rd_en_q <= 1'b1;
        end
      end
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;

endmodule

// File: tb/tb_pcm_frame_packer.sv
// Directed self-checking bench for pcm_frame_packer (2ch x 16b main instance,
// plus a 2ch x 12b instance for sign extension).
module tb_pcm_frame_packer;

`ifdef PACKER_HEADER_EN
  localparam int unsigned HDR = 2;
`else
  localparam int unsigned HDR = 0;
`endif
  localparam int unsigned FB   = 4 + HDR;
  localparam logic [7:0]  FILL = 8'hEE;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic [31:0] sample_data = '0;
  logic [23:0] sample_data12 = '0;
  logic        fifo_full = 1'b0;
  logic [19:0] fifo_free = 20'd100;
  logic [7:0]  fifo_rd_data = 8'h00;
  logic        fifo_empty = 1'b1;
  logic        spi_busy = 1'b0;
  logic        stat_clr = 1'b0;
  logic [7:0]  rd_head = 8'h00;

  logic        fifo_wr_en, fifo_rd_en, tx_valid, overrun;
  logic [7:0]  fifo_wr_data, tx_data;
  logic [15:0] drop_count;

  logic        wr_en12, rd_en12, tx_valid12, overrun12;
  logic [7:0]  wr_data12, tx_data12;
  logic [15:0] drop_count12;

  pcm_frame_packer #(
    .NUM_CHANNELS (2),
    .SAMPLE_WIDTH (16),
    .FREE_WIDTH   (20),
    .FILL_BYTE    (FILL)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_full    (fifo_full),
    .fifo_free    (fifo_free),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .spi_busy     (spi_busy),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .stat_clr     (stat_clr),
    .drop_count   (drop_count),
    .overrun      (overrun)
  );

  pcm_frame_packer #(
    .NUM_CHANNELS (2),
    .SAMPLE_WIDTH (12),
    .FREE_WIDTH   (20),
    .FILL_BYTE    (8'h00)
  ) u_dut12 (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample_data  (sample_data12),
    .fifo_wr_en   (wr_en12),
    .fifo_wr_data (wr_data12),
    .fifo_full    (fifo_full),
    .fifo_free    (fifo_free),
    .fifo_rd_en   (rd_en12),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .spi_busy     (spi_busy),
    .tx_data      (tx_data12),
    .tx_valid     (tx_valid12),
    .stat_clr     (stat_clr),
    .drop_count   (drop_count12),
    .overrun      (overrun12)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External FIFO read port: data appears the cycle after the strobe.
  always @(posedge clk) fifo_rd_data <= fifo_rd_en ? rd_head : 8'h00;

  // Monitors, sampled on the falling edge.
  logic [7:0]  wr_q[$];
  int unsigned wr_t[$];
  logic [7:0]  wr12_q[$];
  int unsigned rd_cnt = 0, rd_last = 0, tv_cnt = 0, tv_last = 0;
  logic [7:0]  tv_data = 8'h00;

  always @(negedge clk) begin
    if (fifo_wr_en) begin
      wr_q.push_back(fifo_wr_data);
      wr_t.push_back(cyc);
    end
    if (wr_en12) wr12_q.push_back(wr_data12);
    if (fifo_rd_en) begin
      rd_cnt  = rd_cnt + 1;
      rd_last = cyc;
    end
    if (tx_valid) begin
      tv_cnt  = tv_cnt + 1;
      tv_last = cyc;
      tv_data = tx_data;
    end
  end

  int unsigned n_cmp = 0, n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_valid(input logic [31:0] d);
    sample_data  = d;
    sample_valid = 1'b1;
    tick(1);
    sample_valid = 1'b0;
  endtask

  logic [7:0] exp_q[$];
`ifdef PACKER_HEADER_EN
  logic [7:0] exp_seq = 8'd0;
`endif

  // Expected bytes of one 2ch x 16b frame.
  task automatic push_frame(input logic [31:0] d);
`ifdef PACKER_HEADER_EN
    exp_q.push_back(8'hA5);
    exp_q.push_back(exp_seq);
    exp_seq = exp_seq + 8'd1;
`endif
    exp_q.push_back(d[7:0]);
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[23:16]);
    exp_q.push_back(d[31:24]);
  endtask

  task automatic cmp_writes(input string tag, input int unsigned base);
    check_eq({tag, "_len"}, wr_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < wr_q.size()) check_eq({tag, "_byte"}, wr_q[base + i], exp_q[i]);
    end
  endtask

  initial begin
    int unsigned base, base12, t0, r0, v0, n;

    // Reset state
    tick(3);
    check_eq("rst_wr_en", fifo_wr_en, 1'b0);
    check_eq("rst_rd_en", fifo_rd_en, 1'b0);
    check_eq("rst_tx_valid", tx_valid, 1'b0);
    check_eq("rst_tx_data", tx_data, FILL);
    check_eq("rst_drop", drop_count, 16'd0);
    check_eq("rst_overrun", overrun, 1'b0);
    rst = 1'b0;
    tick(2);

    // Basic frame plus sign extension on the 12-bit instance
    base   = wr_q.size();
    base12 = wr12_q.size();
    sample_data12 = {12'h7FF, 12'h801};
    t0 = cyc;
    pulse_valid(32'h1234_ABCD);
    tick(FB + 3);
    exp_q.delete();
    push_frame(32'h1234_ABCD);
    cmp_writes("basic", base);
    for (int i = 0; i < FB; i++) begin
      if (base + i < wr_t.size()) check_eq("basic_cycle", wr_t[base + i], t0 + 1 + i);
    end
    check_eq("sext_len", wr12_q.size() - base12, FB);
    if (wr12_q.size() >= base12 + FB) begin
      check_eq("sext_801_lo", wr12_q[base12 + HDR + 0], 8'h01);
      check_eq("sext_801_hi", wr12_q[base12 + HDR + 1], 8'hF8);
      check_eq("sext_7ff_lo", wr12_q[base12 + HDR + 2], 8'hFF);
      check_eq("sext_7ff_hi", wr12_q[base12 + HDR + 3], 8'h07);
    end

    // Space drop, then statistics clear
    base = wr_q.size();
    fifo_free = 20'(FB - 1);
    pulse_valid(32'hDEAD_BEEF);
    tick(FB + 2);
    check_eq("drop_no_write", wr_q.size() - base, 0);
    check_eq("drop_count", drop_count, 16'd1);
    check_eq("drop_overrun", overrun, 1'b1);
    stat_clr = 1'b1;
    tick(1);
    stat_clr = 1'b0;
    check_eq("clr_count", drop_count, 16'd0);
    check_eq("clr_overrun", overrun, 1'b0);
    fifo_free = 20'd100;

    // Overrun during EMIT and a 5-cycle full stall mid-frame
    base = wr_q.size();
    sample_data  = 32'h89AB_4567;
    sample_valid = 1'b1;
    tick(1);
    sample_data  = 32'h0F0F_F0F0;
    tick(1);
    sample_valid = 1'b0;
    tick(1);
    fifo_full = 1'b1;
    tick(5);
    fifo_full = 1'b0;
    tick(FB + 3);
    exp_q.delete();
    push_frame(32'h89AB_4567);
    cmp_writes("stall", base);
    if (wr_t.size() >= base + 3) check_eq("stall_gap", wr_t[base + 2] - wr_t[base + 1], 6);
    check_eq("ovr_count", drop_count, 16'd1);
    check_eq("ovr_flag", overrun, 1'b1);

    // Clear coinciding with a drop: the clear wins
    base = wr_q.size();
    pulse_valid(32'h5555_AAAA);
    sample_valid = 1'b1;
    stat_clr     = 1'b1;
    tick(1);
    sample_valid = 1'b0;
    stat_clr     = 1'b0;
    tick(FB + 2);
    exp_q.delete();
    push_frame(32'h5555_AAAA);
    cmp_writes("clrwin", base);
    check_eq("clrwin_count", drop_count, 16'd0);
    check_eq("clrwin_overrun", overrun, 1'b0);

    // Frame, space drop, frame: sequence stays gap-free
    base = wr_q.size();
    pulse_valid(32'h0102_0304);
    tick(FB + 2);
    fifo_free = 20'd1;
    pulse_valid(32'hFFFF_FFFF);
    tick(2);
    fifo_free = 20'd100;
    pulse_valid(32'hA0B0_C0D0);
    tick(FB + 2);
    exp_q.delete();
    push_frame(32'h0102_0304);
    push_frame(32'hA0B0_C0D0);
    cmp_writes("seq", base);
    check_eq("seq_drop", drop_count, 16'd1);

    // SPI read with an empty FIFO: fill byte, no FIFO read
    r0 = rd_cnt;
    v0 = tv_cnt;
    t0 = cyc;
    fifo_empty = 1'b1;
    spi_busy   = 1'b1;
    for (int i = 0; i < 10 && tv_cnt == v0; i++) tick(1);
    tick(3);
    check_eq("fill_pulses", tv_cnt - v0, 1);
    check_eq("fill_data", tv_data, FILL);
    check_eq("fill_no_rd", rd_cnt - r0, 0);
    check_eq("fill_latency_ok", (tv_last - t0 >= 3) && (tv_last - t0 <= 4), 1'b1);
    spi_busy = 1'b0;
    tick(5);

    // SPI read with head byte 5A
    r0 = rd_cnt;
    v0 = tv_cnt;
    fifo_empty = 1'b0;
    rd_head    = 8'h5A;
    spi_busy   = 1'b1;
    for (int i = 0; i < 12 && tv_cnt == v0; i++) tick(1);
    tick(3);
    check_eq("rd_pulses", rd_cnt - r0, 1);
    check_eq("rd_tx_pulses", tv_cnt - v0, 1);
    check_eq("rd_tx_data", tv_data, 8'h5A);
    check_eq("rd_tx_delay", tv_last - rd_last, 2);
    spi_busy   = 1'b0;
    fifo_empty = 1'b1;
    tick(5);

    // Reset mid-EMIT: partial frame abandoned, nothing resumes
    base = wr_q.size();
    pulse_valid(32'h7777_8888);
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_eq("rstmid_partial", wr_q.size() - base, 2);
    n = wr_q.size();
    tick(FB + 2);
    check_eq("rstmid_no_resume", wr_q.size() - n, 0);
    check_eq("rstmid_drop", drop_count, 16'd0);
`ifdef PACKER_HEADER_EN
    exp_seq = 8'd0;
`endif
    base = wr_q.size();
    pulse_valid(32'hCAFE_F00D);
    tick(FB + 2);
    exp_q.delete();
    push_frame(32'hCAFE_F00D);
    cmp_writes("after_rst", base);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
